// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the boot-time instruction memory loader.
// The core (`top`) imports the widths and boot constants from here so both
// sides agree on the memory geometry and the post-load fetch address.
package imem_loader_pkg;

  localparam int HW_W        = 16;  // upstream stream halfword width
  localparam int INSN_W      = 32;  // instruction word width
  localparam int IMEM_DEPTH  = 16;  // instruction memory depth in words
  localparam int IMEM_ADDR_W = 4;   // clog2(IMEM_DEPTH)

  // Word address the core fetches first once cpu_rst falls.
  localparam logic [INSN_W-1:0] BOOT_PC = '0;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  // A header is usable only when it names 1..depth words.
  function automatic logic hdr_ok(input logic [HW_W-1:0] n, input int depth);
    return (n != '0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-protected program image as a
// halfword stream, writes 32-bit words into instruction memory and keeps the
// core in reset until the image has loaded with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic [HW_W-1:0]   in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              err
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t         state;
  // One extra bit so a full-depth word count is representable.
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   addr_cnt;
  logic [HW_W-1:0]   xacc;
  logic [HW_W-1:0]   hi_half;
  logic              acc;
  logic              last_word;

  assign in_ready  = (state == ST_HDR) || (state == ST_HI) ||
                     (state == ST_LO)  || (state == ST_CHK);
  assign acc       = in_valid & in_ready;
  // addr_cnt never exceeds n_words-1, so the last word ends the write phase
  // before the address could wrap.
  assign last_word = ((addr_cnt + CNT_ONE) == n_words);
  assign load_done = (state == ST_DONE);
  assign err       = (state == ST_ERR);

  // Loader FSM with its datapath and registered memory / core-reset outputs.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      n_words    <= '0;
      addr_cnt   <= '0;
      xacc       <= '0;
      hi_half    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_HDR;
        ST_HDR: if (acc) begin
          if (!hdr_ok(in_data, DEPTH)) begin
            state <= ST_ERR;
          end else begin
            n_words  <= in_data[ADDR_W:0];
            addr_cnt <= '0;
            xacc     <= '0;
            state    <= ST_HI;
          end
        end
        ST_HI: if (acc) begin
          hi_half <= in_data;
          xacc    <= xacc ^ in_data;
          state   <= ST_LO;
        end
        ST_LO: if (acc) begin
          xacc       <= xacc ^ in_data;
          imem_we    <= 1'b1;
          imem_addr  <= addr_cnt[ADDR_W-1:0];
          imem_wdata <= {hi_half, in_data};
          if (last_word) begin
            state <= ST_CHK;
          end else begin
            addr_cnt <= addr_cnt + CNT_ONE;
            state    <= ST_HI;
          end
        end
        // cpu_rst tracks (next state != DONE); DONE is only entered here.
        ST_CHK: if (acc) begin
          if (in_data == xacc) begin
            state   <= ST_DONE;
            cpu_rst <= 1'b0;
          end else begin
            state <= ST_ERR;
          end
        end
        ST_DONE: if (reload) begin
          state   <= ST_HDR;
          cpu_rst <= 1'b1;
        end
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream boot stage for the `top` processor core. Accepts a program image over a 16-bit valid/ready stream and writes 32-bit instruction words into instruction memory. Holds the core in reset until the image is complete and its checksum matches. Releases the core only on a good load; a bad image latches an error.

## Interface
- `DEPTH`, 16: instruction memory depth in 32-bit words.
- `ADDR_W`, 4: instruction memory address width, equal to clog2(DEPTH).

- `clk`  in  1  single system clock; all logic on the rising edge.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  upstream halfword valid.
- `in_data`  in  16  upstream halfword.
- `in_ready`  out  1  loader can accept; combinational decode of state.
- `reload`  in  1  single-cycle pulse that restarts loading from the DONE state.
- `imem_we`  out  1  instruction memory write strobe, registered.
- `imem_addr`  out  ADDR_W  write address, registered.
- `imem_wdata`  out  32  write data, registered; bits [31:16] hold the high halfword.
- `cpu_rst`  out  1  hold-reset to `top`, registered; high until a good load completes.
- `load_done`  out  1  level output; high while in DONE.
- `err`  out  1  level output; high while in ERR.

## Operation
- A halfword is accepted in any cycle where `in_valid & in_ready`. Data is ignored in every other cycle.
- Image format, in order:
  - header N, with 1 ≤ N ≤ DEPTH;
  - 2N instruction halfwords, high half first for each word;
  - one checksum halfword, equal to the XOR of all 2N instruction halfwords (header excluded).
- FSM states: IDLE, HDR, HI, LO, CHK, DONE, ERR.
  - IDLE: the reset state. Moves to HDR unconditionally on the next cycle. `in_ready`=0.
  - HDR: `in_ready`=1. On accept:
    - if N=0 or N>DEPTH, go to ERR;
    - otherwise latch N, clear the address counter and the XOR accumulator, and go to HI.
  - HI: `in_ready`=1. On accept, latch the high half, fold it into the XOR, and go to LO.
  - LO: `in_ready`=1. On accept, fold the low half into the XOR and issue the write. If this is the last word (address counter = N−1), go to CHK; otherwise increment the address and go to HI.
  - CHK: `in_ready`=1. On accept, go to DONE if `in_data` equals the accumulator, else go to ERR.
  - DONE: `in_ready`=0. `reload`=1 moves the FSM to HDR.
  - ERR: `in_ready`=0 and the state is sticky; only `sys_rst` exits it.
- Address counter is ADDR_W+1 bits internally, so N=DEPTH is representable. `imem_addr` never exceeds N−1, and writes never wrap.
- XOR accumulator is 16 bits.
- `reload` is ignored in every state except DONE.

## Timing
- Reset values (held while `sys_rst`=1): state=IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `load_done`=0, `err`=0.
- `in_ready` first goes high in the second cycle after `sys_rst` deasserts (IDLE lasts one cycle).
- `imem_we` is a one-cycle pulse, in the cycle after the LO accept. `imem_addr` and `imem_wdata` are valid in that same cycle.
- `cpu_rst` is registered as (next state != DONE). It falls in the same cycle `load_done` rises, one cycle after the CHK accept.
- On `reload` in DONE:
  - `cpu_rst` rises and `load_done` falls on the next edge;
  - `in_ready` goes high in that same next cycle.
- `in_valid` bubbles stall the FSM with no penalty. Maximum throughput is one halfword per cycle.
- `sys_rst` mid-load aborts immediately (asynchronously) to IDLE. Words already written are left in memory; the next load overwrites them.

## Structure
- Package `imem_loader_pkg` holds:
  - the FSM state enum;
  - the halfword width constant (16) and instruction width constant (32);
  - the boot opcode-independent constants shared with `top`.
- Single module, no sub-module needed. The datapath is only the counter, the XOR accumulator and the high-half register.

## Test plan
- Good load: N=2, halfwords 0x0880, 0x0005, 0x1000, 0x0003, checksum 0x1886 → writes addr0=0x08800005, then addr1=0x10000003. `load_done`=1 and `cpu_rst`=0 one cycle after the checksum accept.
- Bad checksum: same image with checksum 0x1887 → `err`=1 and `cpu_rst` stays 1. `in_ready`=0 and `load_done` never rises. A later `reload` pulse is ignored.
- Bad header: N=0, then (after `sys_rst`) N=17 → `err`=1 the cycle after the header accept, with no `imem_we`.
- Backpressure: good image with `in_valid` toggling every other cycle → writes and final state identical to the good-load case, and exactly 2 `imem_we` pulses.
- Full depth: N=16 with halfwords 0x0000..0x001F → last write at addr 15 with data 0x001E001F. Correct checksum gives DONE and no address wrap.
- Abort and reload:
  - `sys_rst` after 3 instruction halfwords → all outputs return to their reset values, and a subsequent full good load completes.
  - `reload` in DONE → `cpu_rst`=1 next cycle, and a second image loads correctly.
